// File: rtl/trdb_pkg.sv
// -----------------------------------------------------------------------------
// trdb_pkg
// Shared definitions for the trace packet serializer slice:
//   - default packet and output word widths
//   - FIFO entry layout {len, data}
//   - serializer FSM state encoding
// -----------------------------------------------------------------------------
package trdb_pkg;

  // Default widths; the serializer parameters take these as defaults.
  localparam int unsigned TRDB_PACKET_LEN = 128;
  localparam int unsigned TRDB_WORD_LEN   = 32;

  // One buffered packet: clamped length in bits plus masked payload.
  typedef struct packed {
    logic [7:0]                 len;
    logic [TRDB_PACKET_LEN-1:0] data;
  } pkt_entry_t;

  // Serializer states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/trdb_pkt_fifo.sv
// -----------------------------------------------------------------------------
// trdb_pkt_fifo
// Synchronous FIFO of packet entries with registered fill level.
// A push while full is accepted only when a pop happens on the same edge.
// flush_i empties the FIFO on the next edge and overrides push/pop.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   flush_i  synchronous flush
//   push_i   write entry_i
//   entry_i  entry to write
//   pop_i    remove head entry
//   entry_o  head entry (valid when empty_o=0)
//   full_o   FIFO holds DEPTH entries
//   empty_o  FIFO holds no entries
//   level_o  number of stored entries
// -----------------------------------------------------------------------------
module trdb_pkt_fifo
  import trdb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  pkt_entry_t               entry_i,
  input  logic                     pop_i,
  output pkt_entry_t               entry_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  pkt_entry_t         mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]   level_r;

  logic               full_s;
  logic               empty_s;
  logic               write_s;
  logic               read_s;

  assign full_s  = (level_r == LVL_W'(DEPTH));
  assign empty_s = (level_r == {LVL_W{1'b0}});

  // A full FIFO can still take a write when the head leaves on the same edge.
  assign write_s = push_i & (~full_s | (pop_i & ~empty_s));
  assign read_s  = pop_i & ~empty_s;

  // Storage, pointers and level bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (write_s) begin
        mem_r[wr_ptr_r] <= entry_i;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (read_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({write_s, read_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign entry_o = mem_r[rd_ptr_r];
  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign level_o = level_r;

endmodule

// File: rtl/trdb_packet_serializer.sv
// -----------------------------------------------------------------------------
// trdb_packet_serializer
// Buffers variable-length trace packets and streams them out as WORD_LEN-bit
// words, least-significant word first, over a valid/ready handshake. Packets
// arriving while the FIFO is full are dropped and counted.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   clear_i         synchronous flush (FIFO, FSM, drop counter)
//   packet_i        packet payload, bit 0 first
//   packet_len_i    valid bits in packet_i (0 = ignore, >PACKET_LEN clamped)
//   packet_valid_i  single-cycle packet strobe
//   word_o          output word
//   word_valid_o    word_o valid
//   word_ready_i    sink accepts word_o
//   last_o          word_o is the final word of its packet
//   fifo_level_o    packets waiting, excluding the one being serialized
//   drop_cnt_o      dropped packet count, saturating
// -----------------------------------------------------------------------------
module trdb_packet_serializer
  import trdb_pkg::*;
#(
  parameter int unsigned PACKET_LEN = TRDB_PACKET_LEN,
  parameter int unsigned WORD_LEN   = TRDB_WORD_LEN,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic [PACKET_LEN-1:0]         packet_i,
  input  logic [7:0]                    packet_len_i,
  input  logic                          packet_valid_i,
  output logic [WORD_LEN-1:0]           word_o,
  output logic                          word_valid_o,
  input  logic                          word_ready_i,
  output logic                          last_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [15:0]                   drop_cnt_o
);

  localparam int unsigned NWORDS = PACKET_LEN / WORD_LEN;
  localparam int unsigned WL_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  // Keeps payload bits below len, zeroes everything at or above it.
  function automatic logic [PACKET_LEN-1:0] len_mask(input logic [7:0] len);
    logic [PACKET_LEN-1:0] m;
    for (int i = 0; i < int'(PACKET_LEN); i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  // Number of words after the first one: ceil(len/WORD_LEN) - 1.
  function automatic logic [WL_W-1:0] extra_words(input logic [7:0] len);
    logic [8:0] words;
    words = ({1'b0, len} + 9'(WORD_LEN - 1)) / 9'(WORD_LEN);
    return WL_W'(words - 9'd1);
  endfunction

  // ---------------------------------------------------------------------------
  // Input capture
  // ---------------------------------------------------------------------------
  logic [7:0]  len_clamp_s;
  logic        strobe_s;
  pkt_entry_t  entry_in_s;
  pkt_entry_t  head_s;
  logic        full_s;
  logic        empty_s;
  logic        pop_s;
  logic        drop_s;

  // Clamp oversize lengths so word count and mask stay in range.
  always_comb begin
    len_clamp_s = packet_len_i;
    if ({1'b0, packet_len_i} > 9'(PACKET_LEN)) begin
      len_clamp_s = 8'(PACKET_LEN);
    end else begin
      len_clamp_s = packet_len_i;
    end
  end

  // Zero-length strobes and strobes coinciding with a flush never reach the FIFO.
  assign strobe_s        = packet_valid_i & (packet_len_i != 8'd0) & ~clear_i;
  assign entry_in_s.len  = len_clamp_s;
  assign entry_in_s.data = packet_i & len_mask(len_clamp_s);
  assign drop_s          = strobe_s & full_s & ~pop_s;

  trdb_pkt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (strobe_s),
    .entry_i (entry_in_s),
    .pop_i   (pop_s),
    .entry_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (fifo_level_o)
  );

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  ser_state_e            state_r;
  ser_state_e            state_n;
  logic [PACKET_LEN-1:0] shift_r;
  logic [PACKET_LEN-1:0] shift_n;
  logic [WL_W-1:0]       words_left_r;
  logic [WL_W-1:0]       words_left_n;
  logic                  valid_r;
  logic                  valid_n;
  logic                  last_r;
  logic                  last_n;
  logic [WL_W-1:0]       head_extra_s;

  assign head_extra_s = extra_words(head_s.len);

  // Next-state, pop request and output register values.
  always_comb begin
    state_n      = state_r;
    shift_n      = shift_r;
    words_left_n = words_left_r;
    valid_n      = valid_r;
    last_n       = last_r;
    pop_s        = 1'b0;
    if (clear_i) begin
      state_n      = ST_IDLE;
      shift_n      = {PACKET_LEN{1'b0}};
      words_left_n = {WL_W{1'b0}};
      valid_n      = 1'b0;
      last_n       = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            pop_s        = 1'b1;
            state_n      = ST_SEND;
            shift_n      = head_s.data;
            words_left_n = head_extra_s;
            valid_n      = 1'b1;
            last_n       = (head_extra_s == {WL_W{1'b0}});
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_SEND: begin
          if (valid_r && word_ready_i) begin
            if (words_left_r == {WL_W{1'b0}}) begin
              // Final word accepted: chain straight into the next packet.
              if (!empty_s) begin
                pop_s        = 1'b1;
                state_n      = ST_SEND;
                shift_n      = head_s.data;
                words_left_n = head_extra_s;
                valid_n      = 1'b1;
                last_n       = (head_extra_s == {WL_W{1'b0}});
              end else begin
                state_n      = ST_IDLE;
                shift_n      = {PACKET_LEN{1'b0}};
                words_left_n = {WL_W{1'b0}};
                valid_n      = 1'b0;
                last_n       = 1'b0;
              end
            end else begin
              shift_n      = shift_r >> WORD_LEN;
              words_left_n = words_left_r - WL_W'(1);
              valid_n      = 1'b1;
              last_n       = (words_left_r == WL_W'(1));
            end
          end else begin
            state_n = ST_SEND;
          end
        end
        default: begin
          state_n      = ST_IDLE;
          shift_n      = {PACKET_LEN{1'b0}};
          words_left_n = {WL_W{1'b0}};
          valid_n      = 1'b0;
          last_n       = 1'b0;
        end
      endcase
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      shift_r      <= {PACKET_LEN{1'b0}};
      words_left_r <= {WL_W{1'b0}};
      valid_r      <= 1'b0;
      last_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      shift_r      <= shift_n;
      words_left_r <= words_left_n;
      valid_r      <= valid_n;
      last_r       <= last_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter
  // ---------------------------------------------------------------------------
  logic [15:0] drop_cnt_r;

  // Saturating count of packets refused by a full FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_r <= 16'd0;
    end else if (clear_i) begin
      drop_cnt_r <= 16'd0;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign word_o       = shift_r[WORD_LEN-1:0];
  assign word_valid_o = valid_r;
  assign last_o       = last_r;
  assign drop_cnt_o   = drop_cnt_r;

endmodule

// File: tb/tb_trdb_packet_serializer.sv
// -----------------------------------------------------------------------------
// tb_trdb_packet_serializer
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a packet-level reference model (queue of packets + current packet).
// -----------------------------------------------------------------------------
module tb_trdb_packet_serializer;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic [127:0]  packet_i = '0;
  logic [7:0]    packet_len_i = 8'd0;
  logic          packet_valid_i = 1'b0;
  logic [31:0]   word_o;
  logic          word_valid_o;
  logic          word_ready_i = 1'b0;
  logic          last_o;
  logic [2:0]    fifo_level_o;
  logic [15:0]   drop_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  trdb_packet_serializer #(
    .PACKET_LEN (128),
    .WORD_LEN   (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .packet_i       (packet_i),
    .packet_len_i   (packet_len_i),
    .packet_valid_i (packet_valid_i),
    .word_o         (word_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i),
    .last_o         (last_o),
    .fifo_level_o   (fifo_level_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int           n;   // number of words
    logic [127:0] d;   // payload with bits >= len cleared
  } pkt_t;

  pkt_t mq[$];
  pkt_t cur;
  bit   busy = 1'b0;
  int   idx = 0;
  int   drops = 0;

  function automatic pkt_t mk(input logic [7:0] len, input logic [127:0] d);
    pkt_t p;
    int   l;
    l = (int'(len) > 128) ? 128 : int'(len);
    p.d = '0;
    for (int i = 0; i < l; i++) p.d[i] = d[i];
    p.n = (l + 31) / 32;
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    busy  = 1'b0;
    idx   = 0;
    drops = 0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] len, input logic [127:0] d,
                            input bit rdy, input bit clr);
    bit do_pop;
    bit accept;
    if (clr) begin
      model_reset();
    end else begin
      do_pop = (mq.size() > 0) && (!busy || (rdy && idx == cur.n - 1));
      if (busy && rdy) begin
        idx++;
        if (idx == cur.n) busy = 1'b0;
      end
      accept = v && (len != 8'd0) && ((mq.size() < 4) || do_pop);
      if (v && (len != 8'd0) && !accept && drops < 65535) drops++;
      if (do_pop) begin
        cur  = mq.pop_front();
        idx  = 0;
        busy = 1'b1;
      end
      if (accept) mq.push_back(mk(len, d));
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("valid", 64'(word_valid_o), 64'(busy));
    chk("level", 64'(fifo_level_o), 64'(mq.size()));
    chk("drops", 64'(drop_cnt_o), 64'(drops));
    if (busy) begin
      chk("word", 64'(word_o), 64'(cur.d[idx*32 +: 32]));
      chk("last", 64'(last_o), 64'(idx == cur.n - 1));
    end else begin
      chk("last_idle", 64'(last_o), 64'd0);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic cyc(input bit v, input logic [7:0] len, input logic [127:0] d,
                     input bit rdy, input bit clr);
    packet_valid_i = v;
    packet_len_i   = len;
    packet_i       = d;
    word_ready_i   = rdy;
    clear_i        = clr;
    @(posedge clk);
    model_edge(v, len, d, rdy, clr);
    #1;
    check_model();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] all1;
  logic [127:0] s0;
  logic [127:0] dx;
  logic [7:0]   rl;

  initial begin
    all1 = '1;
    model_reset();

    // Reset state
    #12;
    chk("rst word", 64'(word_o), 64'd0);
    chk("rst valid", 64'(word_valid_o), 64'd0);
    chk("rst last", 64'(last_o), 64'd0);
    chk("rst level", 64'(fifo_level_o), 64'd0);
    chk("rst drops", 64'(drop_cnt_o), 64'd0);
    rst_ni = 1'b1;

    // Single 70-bit packet of ones, latency 2 edges
    cyc(1'b1, 8'd70, all1, 1'b1, 1'b0);
    chk("t1 lat valid", 64'(word_valid_o), 64'd0);
    cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
    chk("t1 w0", 64'({word_valid_o, last_o, word_o}), 64'h2_FFFF_FFFF);
    cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
    chk("t1 w1", 64'({word_valid_o, last_o, word_o}), 64'h2_FFFF_FFFF);
    cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
    chk("t1 w2", 64'({word_valid_o, last_o, word_o}), 64'h3_0000_003F);
    cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
    chk("t1 done", 64'(word_valid_o), 64'd0);

    // Back-to-back len=32 then len=128: five words without a gap
    cyc(1'b1, 8'd32, rnd128(), 1'b1, 1'b0);
    cyc(1'b1, 8'd128, rnd128(), 1'b1, 1'b0);
    chk("t2 w1", 64'({word_valid_o, last_o}), 64'd3);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
      chk("t2 wn", 64'({word_valid_o, last_o}), (i == 3) ? 64'd3 : 64'd2);
    end
    cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
    chk("t2 done", 64'(word_valid_o), 64'd0);

    // Stall with six full-length strobes: one in flight, four queued, one dropped
    s0 = rnd128();
    cyc(1'b1, 8'd128, s0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'd128, rnd128(), 1'b0, 1'b0);
      chk("t3 hold", 64'({word_valid_o, last_o, word_o}), {31'd0, 1'b1, 1'b0, s0[31:0]});
    end
    cyc(1'b0, 8'd0, '0, 1'b0, 1'b0);
    chk("t3 level", 64'(fifo_level_o), 64'd4);
    chk("t3 drops", 64'(drop_cnt_o), 64'd1);
    chk("t3 hold2", 64'(word_o), 64'(s0[31:0]));

    // Clear mid-packet together with a strobe
    cyc(1'b1, 8'd128, rnd128(), 1'b1, 1'b1);
    chk("t5 valid", 64'(word_valid_o), 64'd0);
    chk("t5 level", 64'(fifo_level_o), 64'd0);
    chk("t5 drops", 64'(drop_cnt_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
      chk("t5 quiet", 64'(word_valid_o), 64'd0);
    end

    // len=0 ignored, len=200 clamped to 4 words
    cyc(1'b1, 8'd0, all1, 1'b1, 1'b0);
    chk("t4 zero level", 64'(fifo_level_o), 64'd0);
    chk("t4 zero drops", 64'(drop_cnt_o), 64'd0);
    cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
    chk("t4 zero valid", 64'(word_valid_o), 64'd0);
    cyc(1'b1, 8'd200, all1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
      chk("t4 word", 64'({word_valid_o, last_o, word_o}),
          (i == 3) ? 64'h3_FFFF_FFFF : 64'h2_FFFF_FFFF);
    end
    cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
    chk("t4 done", 64'(word_valid_o), 64'd0);

    // Asynchronous reset in the middle of a packet
    cyc(1'b1, 8'd128, rnd128(), 1'b1, 1'b0);
    cyc(1'b1, 8'd96, rnd128(), 1'b1, 1'b0);
    cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
    packet_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6 async", 64'({word_valid_o, last_o, word_o, fifo_level_o, drop_cnt_o}), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("t6 held", 64'({word_valid_o, last_o, word_o}), 64'd0);
    #2;
    rst_ni = 1'b1;
    dx = rnd128();
    cyc(1'b1, 8'd32, dx, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
    chk("t6 word", 64'({word_valid_o, last_o, word_o}), {30'd0, 2'b11, dx[31:0]});
    cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
    chk("t6 done", 64'(word_valid_o), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0:       rl = 8'd0;
        1:       rl = 8'($urandom_range(129, 255));
        default: rl = 8'($urandom_range(1, 128));
      endcase
      cyc($urandom_range(0, 2) != 0, rl, rnd128(),
          $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
    end
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, 8'd0, '0, 1'b1, 1'b0);
    end
    chk("drain valid", 64'(word_valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
